sp_bank_mc: RTL
===============

# sp_bank_mc

Parametrised multi-client scratchpad bank for the tensor core: a single-port SRAM array fronted by a write FIFO and a read-request FIFO, with separate response FIFOs toward DRAM and toward the GEMM array. It adds the following over the first-generation bank:
- parametrised width, depth, FIFO depth and SRAM read latency
- fair write/read arbitration
- read-after-write hazard protection
- credit-based response flow control
- wrap-around load/GEMM completion counters

## Interface
Parameters:
- DATA_W, 64, SRAM word / FIFO data width
- ADDR_W, 8, SRAM address width (2**ADDR_W words)
- FIFO_DEPTH, 4, entries per FIFO (power of two, ≥2)
- RD_LAT, 1, SRAM read latency in cycles (1..3)
- LOAD_ROWS, 4, committed writes per load_complete pulse
- GEMM_ROWS, 4, GEMM-FIFO pops per gemm_complete pulse

Ports:
- CLK  in  1  clock; all logic on rising edge
- nRST  in  1  reset; synchronous, active-low
- wfifo_wen  in  1  push write request
- wfifo_waddr  in  ADDR_W  write address
- wfifo_wdata  in  DATA_W  write data
- wfifo_full  out  1  write FIFO full
- rfifo_wen  in  1  push read request
- rfifo_raddr  in  ADDR_W  read address
- rfifo_dest  in  1  0 = DRAM response FIFO, 1 = GEMM response FIFO
- rfifo_full  out  1  read-request FIFO full
- dram_ren  in  1  pop DRAM response
- dram_rdata  out  DATA_W  DRAM FIFO head (show-ahead)
- dram_empty  out  1  DRAM FIFO empty
- gemm_ren  in  1  pop GEMM response
- gemm_rdata  out  DATA_W  GEMM FIFO head (show-ahead)
- gemm_empty  out  1  GEMM FIFO empty
- load_complete  out  1  one-cycle pulse per LOAD_ROWS committed writes
- gemm_complete  out  1  one-cycle pulse per GEMM_ROWS GEMM pops

## Operation
- All four FIFOs are circular buffers with an occupancy counter of width clog2(FIFO_DEPTH)+1. full = (count == FIFO_DEPTH); empty = (count == 0).
- A push with full=1 is dropped, even if a pop occurs in the same cycle. A pop with empty=1 is ignored. Push and pop in the same cycle on a non-full, non-empty FIFO leave count unchanged.
- rdata outputs drive the head entry. They drive 0 while empty.
- The arbiter grants at most one SRAM access per cycle:
  - W candidate: write FIFO is non-empty.
  - R candidate: read FIFO is non-empty, the head is not hazard-blocked, and the destination has a credit.
  - Only one candidate eligible: it is granted.
  - Both eligible: the one not granted last time wins (last_grant register, reset to R, so W wins first).
- Hazard: the read head is blocked while its raddr matches the waddr of any valid write-FIFO entry. The block clears once that write commits.
- Credits: per destination, credit = FIFO_DEPTH − (count + reads in flight to that destination). A read issues only if credit ≥ 1, so response FIFOs never overflow and responses are never dropped.
- A write grant pops the write FIFO, writes the SRAM, and increments load_cnt. When load_cnt reaches LOAD_ROWS, load_complete pulses the next cycle and load_cnt returns to 0.
- A read grant pops the read FIFO. Address and dest enter an RD_LAT-stage valid pipeline; the SRAM data is pushed to the selected response FIFO.
- Each accepted gemm_ren pop increments gemm_cnt. At GEMM_ROWS, gemm_complete pulses the next cycle and gemm_cnt wraps to 0.
- Reset (nRST=0 at an edge), including mid-operation:
  - Cleared: all FIFO counts and pointers, the read pipeline, in-flight counters, load_cnt and gemm_cnt. last_grant is set to R.
  - Outputs after the reset edge: full=0, empty=1, rdata=0, load_complete=0, gemm_complete=0.
  - SRAM contents are not reset.
  - In-flight reads are discarded.

## Timing
- Push at edge k: the entry is visible to the arbiter in cycle k+1.
- Write granted in cycle g: SRAM is updated at edge g+1. A read of the same address is therefore not granted before cycle g+1.
- Read granted in cycle g: data is pushed at edge g+RD_LAT. The destination empty goes low after that edge.
- Minimum read latency from rfifo_wen to empty=0: RD_LAT+1 edges.
- Full sustained throughput: one SRAM access per cycle.
- Under contention, W and R grants alternate one each.
- load_complete and gemm_complete are registered single-cycle pulses and never assert in two consecutive cycles for the same count.

## Test plan
- Reset: hold nRST=0 for 2 cycles → wfifo_full=0, rfifo_full=0, dram_empty=1, gemm_empty=1, rdata=0, both complete outputs 0.
- Write then read, RD_LAT=1:
  - Stimulus: write 0xDEAD_BEEF to addr 5, then read addr 5 with dest=0.
  - Response: dram_rdata=0xDEAD_BEEF with dram_empty=0 exactly 2 edges after rfifo_wen.
  - After one dram_ren: dram_empty=1.
- RAW hazard:
  - Stimulus: stall the arbiter by holding the read FIFO with a blocked request, queue two writes to addr 3 (0x1 then 0x2), then a read of addr 3.
  - Response: returned data = 0x2, and no read grant occurs while addr 3 is in the write FIFO.
- Credit backpressure, FIFO_DEPTH=4:
  - Stimulus: issue 6 reads with dest=1 and no gemm_ren.
  - Response: gemm FIFO holds 4 entries and 2 requests remain in the read FIFO. Popping gemm FIFO entries one at a time lets the remaining 2 reads issue one per freed slot, and all 6 data words are returned in issue order.
- Arbitration fairness: with both FIFOs continuously non-empty, the grant sequence is W,R,W,R,… and no request is lost.
- Completion counters, LOAD_ROWS=4 / GEMM_ROWS=4:
  - 8 committed writes → exactly 2 load_complete pulses.
  - 5 gemm pops → 1 gemm_complete pulse and gemm_cnt=1.
  - Asserting nRST mid-count → the next pulse requires a full 4 more events.

Source files
------------

// File: rtl/sp_bank_mc.sv
// sp_bank_mc: single-port scratchpad bank with write/read-request FIFOs, fair arbitration,
// RAW hazard blocking and credit-controlled DRAM/GEMM response FIFOs.
module sp_bank_mc #(
  parameter int DATA_W     = 64,
  parameter int ADDR_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int RD_LAT     = 1,
  parameter int LOAD_ROWS  = 4,
  parameter int GEMM_ROWS  = 4
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              wfifo_wen,
  input  logic [ADDR_W-1:0] wfifo_waddr,
  input  logic [DATA_W-1:0] wfifo_wdata,
  output logic              wfifo_full,
  input  logic              rfifo_wen,
  input  logic [ADDR_W-1:0] rfifo_raddr,
  input  logic              rfifo_dest,
  output logic              rfifo_full,
  input  logic              dram_ren,
  output logic [DATA_W-1:0] dram_rdata,
  output logic              dram_empty,
  input  logic              gemm_ren,
  output logic [DATA_W-1:0] gemm_rdata,
  output logic              gemm_empty,
  output logic              load_complete,
  output logic              gemm_complete
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int PL = RD_LAT > 1 ? RD_LAT - 1 : 1;
  localparam int LW = $clog2(LOAD_ROWS + 1);
  localparam int GW = $clog2(GEMM_ROWS + 1);
  localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);
  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [ADDR_W-1:0] wq_a [FIFO_DEPTH];
  logic [DATA_W-1:0] wq_d [FIFO_DEPTH];
  logic [PW-1:0]     wq_rp, wq_wp;
  logic [CW-1:0]     wq_cnt;
  logic [ADDR_W-1:0] rq_a [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] rq_dest;
  logic [PW-1:0]     rq_rp, rq_wp;
  logic [CW-1:0]     rq_cnt;
  logic [DATA_W-1:0] sq_d [2][FIFO_DEPTH];
  logic [PW-1:0]     sq_rp [2], sq_wp [2];
  logic [CW-1:0]     sq_cnt [2], infl [2];
  logic [PL-1:0]     p_v, p_dest;
  logic [DATA_W-1:0] p_d [PL];
  logic [LW-1:0]     load_cnt;
  logic [GW-1:0]     gemm_cnt;
  logic              last_w, haz, w_ok, r_ok, grant_w, grant_r, w_push, r_push, o_v, o_dest, rdest;
  logic [ADDR_W-1:0] ra;
  logic [DATA_W-1:0] o_d;
  logic [1:0]        cr_ok, s_push, s_pop, ren;
  assign wfifo_full = wq_cnt == FULL;
  assign rfifo_full = rq_cnt == FULL;
  assign dram_empty = sq_cnt[0] == '0;
  assign gemm_empty = sq_cnt[1] == '0;
  assign dram_rdata = dram_empty ? '0 : sq_d[0][sq_rp[0]];
  assign gemm_rdata = gemm_empty ? '0 : sq_d[1][sq_rp[1]];
  assign ra     = rq_a[rq_rp];
  assign rdest  = rq_dest[rq_rp];
  assign w_push = wfifo_wen && !wfifo_full;
  assign r_push = rfifo_wen && !rfifo_full;
  assign ren    = {gemm_ren, dram_ren};
  // Block the read head while any queued write targets the same address.
  always_comb begin
    haz = 1'b0;
    for (int i = 0; i < FIFO_DEPTH; i++)
      if ({1'b0, PW'(i) - wq_rp} < wq_cnt && wq_a[i] == ra) haz = 1'b1;
  end
  for (genvar d = 0; d < 2; d++) begin : g_dst
    assign cr_ok[d]  = ({1'b0, sq_cnt[d]} + {1'b0, infl[d]}) < {1'b0, FULL};
    assign s_push[d] = o_v && o_dest == 1'(d) && sq_cnt[d] != FULL;
    assign s_pop[d]  = ren[d] && sq_cnt[d] != '0;
  end
  assign w_ok    = wq_cnt != '0;
  assign r_ok    = rq_cnt != '0 && !haz && cr_ok[rdest];
  assign grant_w = w_ok && (!r_ok || !last_w);
  assign grant_r = r_ok && !grant_w;
  // With RD_LAT=1 the granted word is pushed on the grant edge itself.
  assign o_v    = RD_LAT == 1 ? grant_r : p_v[PL-1];
  assign o_dest = RD_LAT == 1 ? rdest : p_dest[PL-1];
  assign o_d    = RD_LAT == 1 ? mem[ra] : p_d[PL-1];
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      wq_rp <= '0;
      wq_wp <= '0;
      wq_cnt <= '0;
      rq_rp <= '0;
      rq_wp <= '0;
      rq_cnt <= '0;
      last_w <= 1'b0;
      p_v <= '0;
      p_dest <= '0;
      load_cnt <= '0;
      gemm_cnt <= '0;
      load_complete <= 1'b0;
      gemm_complete <= 1'b0;
      for (int d = 0; d < 2; d++) begin
        sq_rp[d] <= '0;
        sq_wp[d] <= '0;
        sq_cnt[d] <= '0;
        infl[d] <= '0;
      end
    end else begin
      if (w_push) wq_wp <= wq_wp + PW'(1);
      if (grant_w) wq_rp <= wq_rp + PW'(1);
      wq_cnt <= wq_cnt + CW'(w_push) - CW'(grant_w);
      if (r_push) begin
        rq_wp <= rq_wp + PW'(1);
        rq_dest[rq_wp] <= rfifo_dest;
      end
      if (grant_r) rq_rp <= rq_rp + PW'(1);
      rq_cnt <= rq_cnt + CW'(r_push) - CW'(grant_r);
      if (grant_w || grant_r) last_w <= grant_w;
      p_v[0] <= grant_r;
      p_dest[0] <= rdest;
      for (int i = 1; i < PL; i++) begin
        p_v[i] <= p_v[i-1];
        p_dest[i] <= p_dest[i-1];
      end
      for (int d = 0; d < 2; d++) begin
        if (s_push[d]) sq_wp[d] <= sq_wp[d] + PW'(1);
        if (s_pop[d]) sq_rp[d] <= sq_rp[d] + PW'(1);
        sq_cnt[d] <= sq_cnt[d] + CW'(s_push[d]) - CW'(s_pop[d]);
        infl[d] <= infl[d] + CW'(grant_r && rdest == 1'(d)) - CW'(o_v && o_dest == 1'(d));
      end
      load_complete <= grant_w && load_cnt == LW'(LOAD_ROWS - 1);
      if (grant_w) load_cnt <= load_cnt == LW'(LOAD_ROWS - 1) ? '0 : load_cnt + LW'(1);
      gemm_complete <= s_pop[1] && gemm_cnt == GW'(GEMM_ROWS - 1);
      if (s_pop[1]) gemm_cnt <= gemm_cnt == GW'(GEMM_ROWS - 1) ? '0 : gemm_cnt + GW'(1);
    end
  end
  // Payload storage carries no reset; occupancy counters alone define validity.
  always_ff @(posedge CLK) begin
    if (nRST && grant_w) mem[wq_a[wq_rp]] <= wq_d[wq_rp];
    if (w_push) begin
      wq_a[wq_wp] <= wfifo_waddr;
      wq_d[wq_wp] <= wfifo_wdata;
    end
    if (r_push) rq_a[rq_wp] <= rfifo_raddr;
    for (int d = 0; d < 2; d++)
      if (s_push[d]) sq_d[d][sq_wp[d]] <= o_d;
    p_d[0] <= mem[ra];
    for (int i = 1; i < PL; i++) p_d[i] <= p_d[i-1];
  end
endmodule
